regfile_scoreboard: RTL and testbench

Write-port controller and scoreboard for the 32×64-bit register file. Tracks which architectural registers have an outstanding write, stalls issue on RAW/WAW hazards, and arbitrates the single register-file write port between the ALU and load/memory writeback sources with a starvation guard. Sits between the issue/decode stage, the two writeback producers, and the register file's `regWrite`/`rd`/`writeData` inputs.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/wb_arbiter.sv | 57 +++++
 rtl/regfile_scoreboard.sv | 111 +++++++++++
 tb/tb_regfile_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port scoreboard.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;

  // Which producer owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_arbiter.sv
// Two-input writeback arbiter: loads (mem) win by default, but the ALU is
// forced through after STARVE_MAX consecutive losses.
module wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    alu_valid,
  input  logic    mem_valid,
  output logic    alu_ready,
  output logic    mem_ready,
  output wb_src_e wb_src
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             starved;

  // Grants depend only on the requests and the starvation count.
  always_comb begin
    starved   = (starve_q == STARVE_LIM);
    mem_ready = !(alu_valid && starved);
    alu_ready = !mem_valid || starved;

    if (mem_valid && mem_ready) begin
      wb_src = WB_MEM;
    end else if (alu_valid && alu_ready) begin
      wb_src = WB_ALU;
    end else begin
      wb_src = WB_NONE;
    end

    // Count only cycles where the ALU asked and lost; any win or idle resets it.
    if (!alu_valid || alu_ready) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file write-port controller and pending-write scoreboard.
// Stalls issue on RAW/WAW hazards and registers the single write port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS   = regfile_pkg::NUM_REGS,
  parameter int ADDR_W     = regfile_pkg::ADDR_W,
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rs1,
  input  logic [ADDR_W-1:0]   iss_rs2,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic                iss_wen,
  output logic                iss_ready,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  output logic                regWrite,
  output logic [ADDR_W-1:0]   rd,
  output logic [DATA_W-1:0]   writeData,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                wb_err
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                wb_err_q, wb_err_d;

  wb_src_e             wb_src;
  logic                wb_acc;
  logic [ADDR_W-1:0]   wb_rd;
  logic [DATA_W-1:0]   wb_data;
  logic                iss_set;

  wb_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_wb_arbiter (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .alu_ready (alu_ready),
    .mem_ready (mem_ready),
    .wb_src    (wb_src)
  );

  // Hazard check uses registered busy bits only; bit 0 is never set.
  always_comb begin
    iss_ready = !(busy_q[iss_rs1] || busy_q[iss_rs2] || (iss_wen && busy_q[iss_rd]));
    iss_set   = iss_valid && iss_ready && iss_wen && (iss_rd != '0);
  end

  // Select the granted writeback and compute next write-port and scoreboard state.
  always_comb begin
    wb_acc  = (wb_src != WB_NONE);
    wb_rd   = (wb_src == WB_MEM) ? mem_rd   : alu_rd;
    wb_data = (wb_src == WB_MEM) ? mem_data : alu_data;

    reg_write_d  = wb_acc && (wb_rd != '0);
    rd_d         = wb_acc ? wb_rd   : rd_q;
    write_data_d = wb_acc ? wb_data : write_data_q;

    // A write to a register nobody is waiting on means the pipeline lost track.
    wb_err_d = wb_err_q || (wb_acc && (wb_rd != '0) && !busy_q[wb_rd]);

    // Clear lands with the register-file write; a same-edge new issue re-sets it.
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (iss_set) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Write-port and scoreboard registers; reset drops any in-flight write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q       <= '0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign regWrite  = reg_write_q;
  assign rd        = rd_q;
  assign writeData = write_data_q;
  assign busy_vec  = busy_q;
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard with a behavioural model.
module tb_regfile_scoreboard;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic          iss_wen = 1'b0;
  logic          iss_ready;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_rd = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_ready;
  logic          regWrite;
  logic [AW-1:0] rd;
  logic [DW-1:0] writeData;
  logic [NR-1:0] busy_vec;
  logic          wb_err;

  regfile_scoreboard #(
    .NUM_REGS   (NR),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (SM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_wen   (iss_wen),
    .iss_ready (iss_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .regWrite  (regWrite),
    .rd        (rd),
    .writeData (writeData),
    .busy_vec  (busy_vec),
    .wb_err    (wb_err)
  );

  always #5 clk = ~clk;

  // Reference model: which registers await a write, the write about to land,
  // how many times in a row the ALU has been turned away, and the error flag.
  bit            pend_m[NR];
  bit            rw_m;
  int            rd_m;
  logic [DW-1:0] wd_m;
  int            losses_m;
  bit            err_m;

  int checks   = 0;
  int failures = 0;

  function automatic bit pending(int r);
    return (r != 0) && pend_m[r];
  endfunction

  function automatic logic [NR-1:0] pend_vec();
    logic [NR-1:0] v;
    v = '0;
    for (int k = 1; k < NR; k++) v[k] = pend_m[k];
    return v;
  endfunction

  function automatic int pick_rd();
    int r;
    r = int'($urandom_range(NR - 1));
    if ($urandom_range(3) != 0) begin
      for (int k = 0; k < NR; k++) begin
        if (pending((r + k) % NR)) return (r + k) % NR;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) pend_m[k] = 1'b0;
    rw_m     = 1'b0;
    rd_m     = 0;
    wd_m     = '0;
    losses_m = 0;
    err_m    = 1'b0;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_wen = 1'b0;
    iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  // One clock: check the handshakes, take the edge, advance the model, check state.
  task automatic cycle();
    bit            exp_iss, exp_mem, exp_alu, take_mem, take_alu, iss_take;
    int            w_rd;
    logic [DW-1:0] w_data;
    #1;
    exp_iss = !(pending(int'(iss_rs1)) || pending(int'(iss_rs2)) ||
                (iss_wen && pending(int'(iss_rd))));
    exp_mem = !(alu_valid && losses_m == SM);
    exp_alu = !mem_valid || losses_m == SM;
    chk("iss_ready", iss_ready, exp_iss);
    chk("mem_ready", mem_ready, exp_mem);
    chk("alu_ready", alu_ready, exp_alu);
    @(posedge clk);
    take_mem = mem_valid && exp_mem;
    take_alu = alu_valid && exp_alu && !take_mem;
    iss_take = iss_valid && exp_iss && iss_wen && iss_rd != '0;
    w_rd   = take_mem ? int'(mem_rd) : int'(alu_rd);
    w_data = take_mem ? mem_data : alu_data;
    if ((take_mem || take_alu) && w_rd != 0 && !pend_m[w_rd]) err_m = 1'b1;
    if (rw_m) pend_m[rd_m] = 1'b0;
    if (iss_take) pend_m[int'(iss_rd)] = 1'b1;
    if (take_mem || take_alu) begin
      rw_m = (w_rd != 0);
      rd_m = w_rd;
      wd_m = w_data;
    end else begin
      rw_m = 1'b0;
    end
    if (alu_valid && !exp_alu) losses_m = (losses_m < SM) ? losses_m + 1 : SM;
    else                       losses_m = 0;
    @(negedge clk);
    chk("regWrite", regWrite, rw_m);
    chk("rd", rd, rd_m[AW-1:0]);
    chk("writeData", writeData, wd_m);
    chk("busy_vec", busy_vec, pend_vec());
    chk("wb_err", wb_err, err_m);
  endtask

  logic [NR-1:0] saved_busy;

  initial begin
    model_reset();
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_vec", busy_vec, '0);
    chk("rst_regWrite", regWrite, 1'b0);
    chk("rst_wb_err", wb_err, 1'b0);
    reset = 1'b1;

    // RAW on x5 resolved by a load writeback.
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd5;
    cycle();
    chk("raw_busy5_set", busy_vec[5], 1'b1);
    iss_wen = 1'b0; iss_rd = '0; iss_rs1 = 5'd5;
    #1;
    chk("raw_stall", iss_ready, 1'b0);
    cycle();
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 64'hDEAD;
    cycle();
    chk("raw_regWrite", regWrite, 1'b1);
    chk("raw_rd", rd, 5'd5);
    chk("raw_writeData", writeData, 64'hDEAD);
    mem_valid = 1'b0;
    cycle();
    chk("raw_busy5_clear", busy_vec[5], 1'b0);
    #1;
    chk("raw_release", iss_ready, 1'b1);
    idle();

    // Both producers valid: mem wins four times, then the ALU gets one slot.
    alu_valid = 1'b1; alu_rd = '0; alu_data = 64'h1111;
    mem_valid = 1'b1; mem_rd = '0; mem_data = 64'h2222;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk("starve_mem_ready", mem_ready, !(i == 5 || i == 10));
      chk("starve_alu_ready", alu_ready, (i == 5 || i == 10));
      cycle();
    end
    idle();

    // x0 is never tracked and never written.
    saved_busy = busy_vec;
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = '0;
    cycle();
    chk("x0_busy_unchanged", busy_vec, saved_busy);
    idle();
    alu_valid = 1'b1; alu_rd = '0; alu_data = 64'h77;
    #1;
    chk("x0_alu_ready", alu_ready, 1'b1);
    cycle();
    chk("x0_regWrite", regWrite, 1'b0);
    chk("x0_wb_err", wb_err, 1'b0);
    idle();

    // WAW on x3: the second writer waits two edges past the first writeback.
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd3;
    cycle();
    #1;
    chk("waw_stall0", iss_ready, 1'b0);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h3333;
    cycle();
    alu_valid = 1'b0;
    #1;
    chk("waw_stall1", iss_ready, 1'b0);
    cycle();
    #1;
    chk("waw_release", iss_ready, 1'b1);
    cycle();
    chk("waw_rebusy", busy_vec[3], 1'b1);
    idle();

    // Writeback to an idle register flags a sticky error but still writes.
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h1;
    cycle();
    chk("err_set", wb_err, 1'b1);
    chk("err_regWrite", regWrite, 1'b1);
    chk("err_rd", rd, 5'd7);
    idle();
    cycle();
    cycle();
    chk("err_sticky", wb_err, 1'b1);

    // Asynchronous reset with pending registers and a write in flight.
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd10;
    cycle();
    iss_rd = 5'd11;
    cycle();
    idle();
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 64'hBEEF;
    cycle();
    chk("pre_rst_regWrite", regWrite, 1'b1);
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_busy_vec", busy_vec, '0);
    chk("async_rst_regWrite", regWrite, 1'b0);
    chk("async_rst_rd", rd, '0);
    chk("async_rst_writeData", writeData, '0);
    chk("async_rst_wb_err", wb_err, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      iss_valid = 1'($urandom_range(1));
      iss_wen   = 1'($urandom_range(1));
      iss_rs1   = AW'($urandom_range(NR - 1));
      iss_rs2   = AW'($urandom_range(NR - 1));
      iss_rd    = AW'($urandom_range(NR - 1));
      alu_valid = ($urandom_range(2) != 0);
      alu_rd    = AW'(pick_rd());
      alu_data  = {$urandom, $urandom};
      mem_valid = ($urandom_range(2) != 0);
      mem_rd    = AW'(pick_rd());
      mem_data  = {$urandom, $urandom};
      cycle();
    end
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
